// File: rtl/refresh_scanner.sv
// refresh_scanner: N-digit display refresh sequencer with prescaler,
// digit skip mask, anti-ghost blanking and slot/frame strobes.
module refresh_scanner #(
  parameter  int DIGITS       = 4,
  parameter  int PRESCALE     = 100000,
  parameter  int BLANK_CYCLES = 1000,
  localparam int SEL_W        = $clog2(DIGITS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DIGITS-1:0] digit_enable,
  output logic [SEL_W-1:0]  digit_select,
  output logic [DIGITS-1:0] anode_n,
  output logic              slot_tick,
  output logic              frame_tick
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic              slot_q, slot_d;
  logic              frame_q, frame_d;

  logic              hit;
  logic [SEL_W-1:0]  nxt;

  // Cyclic search for the next enabled digit after the current one.
  always_comb begin
    int idx;
    idx = 0;
    hit = 1'b0;
    nxt = sel_q;
    for (int k = 1; k <= DIGITS; k++) begin
      idx = int'(sel_q) + k;
      if (idx >= DIGITS) idx = idx - DIGITS;
      if (!hit && digit_enable[idx]) begin
        hit = 1'b1;
        nxt = SEL_W'(idx);
      end
    end
  end

  // Prescaler advance, digit step on wrap, and anode drive from next state.
  always_comb begin
    presc_d = presc_q;
    sel_d   = sel_q;
    slot_d  = 1'b0;
    frame_d = 1'b0;
    anode_d = '1;
    if (enable) begin
      if (presc_q == PW'(PRESCALE - 1)) begin
        presc_d = '0;
        slot_d  = 1'b1;
        if (hit) begin
          sel_d   = nxt;
          frame_d = (nxt <= sel_q);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (int'(presc_d) >= BLANK_CYCLES && digit_enable[sel_d]) begin
        anode_d = ~(DIGITS'(1) << sel_d);
      end
    end
  end

  // State and registered outputs; reset blanks the display immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      sel_q   <= '0;
      anode_q <= '1;
      slot_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      anode_q <= anode_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
    end
  end

  assign digit_select = sel_q;
  assign anode_n      = anode_q;
  assign slot_tick    = slot_q;
  assign frame_tick   = frame_q;

endmodule

// File: tb/tb_refresh_scanner.sv
// tb_refresh_scanner: two scanner configurations checked cycle by
// cycle against a slot-position reference model.
module tb_refresh_scanner;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] mask_a;
  logic [2:0] mask_b;

  logic [1:0] sel_a;
  logic [3:0] an_a;
  logic       st_a, ft_a;
  logic [1:0] sel_b;
  logic [2:0] an_b;
  logic       st_b, ft_b;

  int checks;
  int errors;

  int pa, sa, pb, sb;
  logic xsa, xfa, xsb, xfb;
  logic [15:0] xana, xanb;

  refresh_scanner #(
    .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1)
  ) dut_a (
    .clock(clk), .reset_n(rst_n), .enable(en),
    .digit_enable(mask_a), .digit_select(sel_a),
    .anode_n(an_a), .slot_tick(st_a), .frame_tick(ft_a)
  );

  refresh_scanner #(
    .DIGITS(3), .PRESCALE(2), .BLANK_CYCLES(0)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .enable(en),
    .digit_enable(mask_b), .digit_select(sel_b),
    .anode_n(an_b), .slot_tick(st_b), .frame_tick(ft_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: position within slot, and the enabled digit list.
  task automatic model(input int n, input int p, input int b,
                       input logic [15:0] m, input logic e,
                       inout int pos, inout int sel,
                       output logic sl, output logic fr,
                       output logic [15:0] an);
    int lo, up;
    sl = 1'b0;
    fr = 1'b0;
    if (e) begin
      pos = pos + 1;
      if (pos == p) begin
        pos = 0;
        sl = 1'b1;
        lo = -1;
        up = -1;
        for (int j = n - 1; j >= 0; j--) begin
          if (m[j]) begin
            lo = j;
            if (j > sel) up = j;
          end
        end
        if (up >= 0) sel = up;
        else if (lo >= 0) begin
          sel = lo;
          fr = 1'b1;
        end
      end
    end
    an = 16'hFFFF;
    if (e && pos >= b && m[sel]) an[sel] = 1'b0;
  endtask

  task automatic model_reset();
    pa = 0; sa = 0; pb = 0; sb = 0;
    xsa = 0; xfa = 0; xsb = 0; xfb = 0;
    xana = 16'hFFFF; xanb = 16'hFFFF;
  endtask

  task automatic compare();
    chk("sel_a", 32'(sel_a), 32'(sa));
    chk("an_a", 32'(an_a), 32'(xana[3:0]));
    chk("slot_a", 32'(st_a), 32'(xsa));
    chk("frame_a", 32'(ft_a), 32'(xfa));
    chk("sel_b", 32'(sel_b), 32'(sb));
    chk("an_b", 32'(an_b), 32'(xanb[2:0]));
    chk("slot_b", 32'(st_b), 32'(xsb));
    chk("frame_b", 32'(ft_b), 32'(xfb));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model(4, 4, 1, 16'(mask_a), en, pa, sa, xsa, xfa, xana);
      model(3, 2, 0, 16'(mask_b), en, pb, sb, xsb, xfb, xanb);
    end else begin
      model_reset();
    end
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int guard;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    mask_a = 4'b1111;
    mask_b = 3'b111;
    model_reset();
    run(3);
    rst_n = 1'b1;

    run(20);
    mask_a = 4'b1010;
    run(20);
    mask_a = 4'b0100;
    run(12);
    mask_a = 4'b0000;
    mask_b = 3'b010;
    run(12);
    mask_a = 4'b1111;
    mask_b = 3'b111;

    guard = 0;
    while (!(pa == 2 && sa == 1) && guard < 100) begin
      step();
      guard++;
    end
    chk("reach_p2_s1", 32'(guard < 100), 32'd1);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(10);

    guard = 0;
    while (!(sa == 3 && pa == 1) && guard < 100) begin
      step();
      guard++;
    end
    chk("reach_s3", 32'(guard < 100), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    #2;
    rst_n = 1'b1;
    run(8);

    for (int i = 0; i < 400; i++) begin
      if (i % 7 == 0) begin
        mask_a = 4'($urandom_range(0, 15));
        mask_b = 3'($urandom_range(0, 7));
      end
      en = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
